// File: rtl/mem_responder.sv
// mem_responder: single-outstanding load/store responder in front of a word-organised array.
// Latency: request accepted at edge N gives a one-cycle ready pulse in cycle N+WAIT_STATES+1.
// Backpressure: req is sampled only in IDLE; busy=1 in WAIT/RESP, next accept is the cycle after ready.
// Ports: clk, reset (async, active-low); req/we/adr/wdata/size request; rdata/ready/err response; busy.
// Optional feature macro MEM_RESP_ERR_EN: flag illegal-size, misaligned and out-of-range accesses on err.
module mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] adr,
   input  logic [31:0] wdata,
   input  logic [2:0]  size,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);
   localparam int         AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [AW+1:0] adr_q, adr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [2:0]    size_q, size_d;
   logic          fault_q, fault_d;
   logic          ready_q, ready_d;
   logic          err_q, err_d;
   logic          busy_q, busy_d;
   logic [31:0]   rdata_q, rdata_d;

   logic [31:0]   mem [DEPTH_WORDS];

   logic          in_fault;
   logic          enter_resp;
   logic [AW+1:0] rsp_adr;
   logic [2:0]    rsp_size;
   logic          rsp_we;
   logic          rsp_fault;
   logic [31:0]   rd_word;
   logic          wr_en;
   logic [3:0]    be;
   logic [31:0]   wr_dat;
   logic          unused_adr_hi;

   // Index bits above the array size only matter for fault detection.
   assign unused_adr_hi = ^adr[31:AW+2];

`ifdef MEM_RESP_ERR_EN
   always_comb begin
      in_fault = 1'b0;
      case (size)
         3'b011, 3'b110, 3'b111: in_fault = 1'b1;
         3'b001, 3'b101:         in_fault = adr[0];
         3'b010:                 in_fault = |adr[1:0];
         default:                in_fault = 1'b0;
      endcase
      if (|adr[31:AW+2]) in_fault = 1'b1;
   end
`else
   assign in_fault = 1'b0;
`endif

   // Lane select and extension; any size other than b/h (incl. illegal codes) acts as a word.
   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [2:0] sz);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lane, 3'b000} +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (sz[1:0])
         2'b00:   load_ext = {{24{b[7] & ~sz[2]}}, b};
         2'b01:   load_ext = {{16{h[15] & ~sz[2]}}, h};
         default: load_ext = w;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      adr_d      = adr_q;
      wdata_d    = wdata_q;
      size_d     = size_q;
      fault_d    = fault_q;
      busy_d     = busy_q;
      enter_resp = 1'b0;
      // With zero wait states the access enters RESP on the accepting edge, so the
      // response must be formed from the live request instead of the latched copy.
      rsp_adr    = adr_q;
      rsp_size   = size_q;
      rsp_we     = we_q;
      rsp_fault  = fault_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               we_d    = we;
               adr_d   = adr[AW+1:0];
               wdata_d = wdata;
               size_d  = size;
               fault_d = in_fault;
               cnt_d   = WS;
               busy_d  = 1'b1;
               if (WS == 4'd0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
                  rsp_adr    = adr[AW+1:0];
                  rsp_size   = size;
                  rsp_we     = we;
                  rsp_fault  = in_fault;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      // Read port: array data is captured into rdata_q on the edge that enters RESP.
      rd_word = mem[rsp_adr[AW+1:2]];
      ready_d = enter_resp;
      err_d   = enter_resp & rsp_fault;
      rdata_d = (enter_resp && !rsp_we && !rsp_fault) ?
                load_ext(rd_word, rsp_adr[1:0], rsp_size) : 32'd0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         wdata_q <= 32'd0;
         size_q  <= 3'd0;
         fault_q <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         fault_q <= fault_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         rdata_q <= rdata_d;
      end
   end

   // Write port: lanes are committed on the edge leaving RESP. A reset mid-access forces
   // IDLE asynchronously, so the pending store never reaches this edge.
   always_comb begin
      wr_en = (state_q == RESP) && we_q && !fault_q;
      case (size_q[1:0])
         2'b00: begin
            be     = 4'b0001 << adr_q[1:0];
            wr_dat = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be     = adr_q[1] ? 4'b1100 : 4'b0011;
            wr_dat = {2{wdata_q[15:0]}};
         end
         default: begin
            be     = 4'b1111;
            wr_dat = wdata_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[adr_q[AW+1:2]][8*i +: 8] <= wr_dat[8*i +: 8];
         end
      end
   end

   assign rdata = rdata_q;
   assign ready = ready_q;
   assign err   = err_q;
   assign busy  = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
   localparam int DEPTH = 256;
   localparam int WS    = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, req, we, ready, err, busy;
   logic [31:0] adr, wdata, rdata;
   logic [2:0]  size;
   logic        req0, we0, ready0, err0, busy0;
   logic [31:0] adr0, wdata0, rdata0;
   logic [2:0]  size0;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference memory as a flat byte array.
   logic [7:0] mb [4*DEPTH];

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .adr(adr), .wdata(wdata), .size(size),
      .rdata(rdata), .ready(ready), .err(err), .busy(busy));

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .req(req0), .we(we0), .adr(adr0), .wdata(wdata0), .size(size0),
      .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0));

   function automatic logic model_fault(input logic [31:0] a, input logic [2:0] s);
      logic bad;
      bad = (s == 3'b011) || (s == 3'b110) || (s == 3'b111);
      if ((s == 3'b001 || s == 3'b101) && (a % 2 != 0)) bad = 1'b1;
      if (s == 3'b010 && (a % 4 != 0)) bad = 1'b1;
      if (a / 4 >= DEPTH) bad = 1'b1;
`ifdef MEM_RESP_ERR_EN
      return bad;
`else
      return bad & 1'b0;
`endif
   endfunction

   function automatic int nbytes(input logic [2:0] s);
      case (s)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic int base_byte(input logic [31:0] a, input logic [2:0] s);
      int w, off;
      w   = int'((a / 4) % DEPTH);
      off = int'(a % 4);
      off = off - (off % nbytes(s));
      return w * 4 + off;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] s);
      logic [31:0] v;
      int n, b;
      if (model_fault(a, s)) return 32'd0;
      n = nbytes(s);
      b = base_byte(a, s);
      v = 32'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[b + i];
      if (n < 4 && !s[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
      int n, b;
      if (model_fault(a, s)) return;
      n = nbytes(s);
      b = base_byte(a, s);
      for (int i = 0; i < n; i++) mb[b + i] = d[8*i +: 8];
   endtask

   // One access on the WAIT_STATES=2 instance; scrambles the request inputs while busy.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] s, output logic [31:0] rd, output logic e,
                         output int lat);
      @(negedge clk);
      req = 1'b1; we = w; adr = a; wdata = d; size = s;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!ready) begin
            req = 1'($urandom); we = 1'($urandom); adr = $urandom;
            wdata = $urandom; size = 3'($urandom);
         end
      end while (!ready && lat < 40);
      req = 1'b0;
      rd = rdata;
      e  = err;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic e;
      int lat;
      access(1'b1, 32'h0, 32'hDEAD_BEEF, 3'b010, rd, e, lat);
      model_store(32'h0, 32'hDEAD_BEEF, 3'b010);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({ready, err, busy, rdata} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b err=%b busy=%b rdata=%h, required all 0",
                  ready, err, busy, rdata);
      end
      n_cmp++;
      if ({ready0, err0, busy0, rdata0} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_outputs_ws0: ready=%b err=%b busy=%b rdata=%h, required all 0",
                  ready0, err0, busy0, rdata0);
      end
      access(1'b0, 32'h0, 32'h0, 3'b010, rd, e, lat);
      n_cmp++;
      if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_keeps_array: rdata=%h err=%b, required deadbeef err=0", rd, e);
      end
   endtask

   task automatic test_timing();
      logic [31:0] rd;
      logic e;
      int lat;
      @(negedge clk);
      req = 1'b1; we = 1'b1; adr = 32'h10; wdata = 32'h1234_5678; size = 3'b010;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         req = 1'b0;
         n_cmp++;
         if (ready !== (k == WS + 1) || busy !== (k <= WS + 1) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL timing_cycle%0d: ready=%b busy=%b err=%b, required ready=%b busy=%b err=0",
                     k, ready, busy, err, (k == WS + 1), (k <= WS + 1));
         end
      end
      model_store(32'h10, 32'h1234_5678, 3'b010);
      access(1'b0, 32'h10, 32'h0, 3'b010, rd, e, lat);
      n_cmp++;
      if (rd !== 32'h1234_5678 || e !== 1'b0 || lat != WS + 1) begin
         n_fail++;
         $display("FAIL timing_lw: rdata=%h err=%b lat=%0d, required 12345678 err=0 lat=%0d",
                  rd, e, lat, WS + 1);
      end
   endtask

   task automatic test_extend();
      logic [31:0] rd, a, exp;
      logic [2:0] s;
      logic e;
      int lat;
      access(1'b1, 32'h20, 32'h80FF_7F01, 3'b010, rd, e, lat);
      model_store(32'h20, 32'h80FF_7F01, 3'b010);
      for (int i = 0; i < 4; i++) begin
         case (i)
            0:       begin a = 32'h23; s = 3'b000; exp = 32'hFFFF_FF80; end
            1:       begin a = 32'h23; s = 3'b100; exp = 32'h0000_0080; end
            2:       begin a = 32'h22; s = 3'b001; exp = 32'hFFFF_80FF; end
            default: begin a = 32'h20; s = 3'b101; exp = 32'h0000_7F01; end
         endcase
         access(1'b0, a, 32'h0, s, rd, e, lat);
         n_cmp++;
         if (rd !== exp || e !== 1'b0 || lat != WS + 1) begin
            n_fail++;
            $display("FAIL extend_%0d: adr=%h size=%b rdata=%h err=%b lat=%0d, required %h err=0 lat=%0d",
                     i, a, s, rd, e, lat, exp, WS + 1);
         end
      end
   endtask

   task automatic test_lanes();
      logic [31:0] rd;
      logic e;
      int lat;
      access(1'b1, 32'h20, 32'h0, 3'b010, rd, e, lat);
      model_store(32'h20, 32'h0, 3'b010);
      access(1'b1, 32'h21, 32'h0000_00AA, 3'b000, rd, e, lat);
      model_store(32'h21, 32'h0000_00AA, 3'b000);
      n_cmp++;
      if (rd !== 32'd0 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL store_rdata: rdata=%h err=%b, required 0 err=0", rd, e);
      end
      access(1'b0, 32'h20, 32'h0, 3'b010, rd, e, lat);
      n_cmp++;
      if (rd !== 32'h0000_AA00) begin
         n_fail++;
         $display("FAIL sb_lane: rdata=%h, required 0000aa00", rd);
      end
      access(1'b1, 32'h22, 32'h0000_BEEF, 3'b001, rd, e, lat);
      model_store(32'h22, 32'h0000_BEEF, 3'b001);
      access(1'b0, 32'h20, 32'h0, 3'b010, rd, e, lat);
      n_cmp++;
      if (rd !== 32'hBEEF_AA00) begin
         n_fail++;
         $display("FAIL sh_lane: rdata=%h, required beefaa00", rd);
      end
   endtask

   task automatic test_faults();
      logic [31:0] rd, a, d, exp_rd;
      logic [2:0] s;
      logic w, e, exp_e;
      int lat;
      access(1'b1, 32'h4, 32'hCAFE_F00D, 3'b010, rd, e, lat);
      model_store(32'h4, 32'hCAFE_F00D, 3'b010);
      for (int i = 0; i < 6; i++) begin
         w = 1'b0; d = 32'h0;
         case (i)
            0:       begin a = 32'h6;       s = 3'b010; end
            1:       begin a = 32'h6;       s = 3'b010; w = 1'b1; d = 32'h5555_5555; end
            2:       begin a = 32'h4;       s = 3'b010; end
            3:       begin a = 4 * DEPTH;   s = 3'b010; end
            4:       begin a = 32'h7;       s = 3'b001; end
            default: begin a = 32'h4;       s = 3'b011; end
         endcase
         exp_e  = model_fault(a, s);
         exp_rd = w ? 32'd0 : model_load(a, s);
         access(w, a, d, s, rd, e, lat);
         if (w) model_store(a, d, s);
         n_cmp++;
         if (rd !== exp_rd || e !== exp_e || lat != WS + 1) begin
            n_fail++;
            $display("FAIL fault_%0d: adr=%h size=%b we=%b rdata=%h err=%b lat=%0d, required %h err=%b lat=%0d",
                     i, a, s, w, rd, e, lat, exp_rd, exp_e, WS + 1);
         end
      end
      access(1'b0, 32'h4, 32'h0, 3'b010, rd, e, lat);
      n_cmp++;
`ifdef MEM_RESP_ERR_EN
      if (rd !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL faulted_store_no_write: rdata=%h, required cafef00d", rd);
      end
`else
      if (rd !== 32'h5555_5555) begin
         n_fail++;
         $display("FAIL misaligned_store_aligned_down: rdata=%h, required 55555555", rd);
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      d = $urandom;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; adr0 = 32'h8; wdata0 = d; size0 = 3'b010;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         n_cmp++;
         if (ready0 !== k[0] || busy0 !== k[0]) begin
            n_fail++;
            $display("FAIL b2b_cycle%0d: ready=%b busy=%b, required ready=%b busy=%b",
                     k, ready0, busy0, k[0], k[0]);
         end
      end
      req0 = 1'b1; we0 = 1'b0;
      @(negedge clk);
      req0 = 1'b0;
      n_cmp++;
      if (ready0 !== 1'b1 || rdata0 !== d || err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_load: ready=%b rdata=%h err=%b, required ready=1 rdata=%h err=0",
                  ready0, rdata0, err0, d);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic e, seen;
      int lat;
      access(1'b1, 32'h30, 32'h1111_1111, 3'b010, rd, e, lat);
      model_store(32'h30, 32'h1111_1111, 3'b010);
      @(negedge clk);
      req = 1'b1; we = 1'b1; adr = 32'h30; wdata = 32'h2222_2222; size = 3'b010;
      @(negedge clk);
      req = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ready) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_ready: ready pulsed=%b, required 0", seen);
      end
      access(1'b0, 32'h30, 32'h0, 3'b010, rd, e, lat);
      n_cmp++;
      if (rd !== 32'h1111_1111) begin
         n_fail++;
         $display("FAIL reset_mid_nowrite: rdata=%h, required 11111111", rd);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, a, d, exp_rd;
      logic [2:0] s;
      logic w, e, exp_e;
      int lat;
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         access(1'b1, 32'(4 * i), d, 3'b010, rd, e, lat);
         model_store(32'(4 * i), d, 3'b010);
      end
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 7))
            0:       s = 3'b000;
            1:       s = 3'b001;
            2:       s = 3'b100;
            3:       s = 3'b101;
            4:       s = 3'b011;
            5:       s = 3'($urandom_range(6, 7));
            default: s = 3'b010;
         endcase
         a = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) a = a + 4 * DEPTH;
         w = 1'($urandom);
         d = $urandom;
         exp_e  = model_fault(a, s);
         exp_rd = w ? 32'd0 : model_load(a, s);
         access(w, a, d, s, rd, e, lat);
         if (w) model_store(a, d, s);
         n_cmp++;
         if (rd !== exp_rd || e !== exp_e || lat != WS + 1) begin
            n_fail++;
            $display("FAIL random_%0d: adr=%h size=%b we=%b rdata=%h err=%b lat=%0d, required %h err=%b lat=%0d",
                     i, a, s, w, rd, e, lat, exp_rd, exp_e, WS + 1);
         end
      end
   endtask

   initial begin
      reset = 1'b0; req = 1'b0; we = 1'b0; adr = 32'h0; wdata = 32'h0; size = 3'b010;
      req0 = 1'b0; we0 = 1'b0; adr0 = 32'h0; wdata0 = 32'h0; size0 = 3'b010;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      test_reset();
      test_timing();
      test_extend();
      test_lanes();
      test_faults();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1);
   end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle CPU's unified instruction/data memory port. It accepts one load or store request at a time from the controller/datapath, inserts a fixed number of wait states, and performs the access. Byte, halfword and word stores use byte lanes; loads are sign- or zero-extended. The result is returned with a single-cycle `ready` pulse. It sits between the datapath's address/write-data path and the word-organised memory array, and replaces the zero-latency combinational memory.

## Interface
- `DEPTH_WORDS`, default 256: memory size in 32-bit words; power of two.
- `WAIT_STATES`, default 2: cycles spent in WAIT per access; 0 to 15.
- `clk`  input  1  clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `req`  input  1  access request; sampled only in IDLE.
- `we`  input  1  1 = store, 0 = load.
- `adr`  input  32  byte address.
- `wdata`  input  32  store data; right-aligned for byte and halfword.
- `size`  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `rdata`  output  32  extended load data; valid only while `ready`=1.
- `ready`  output  1  one-cycle completion pulse.
- `err`  output  1  access faulted; valid only while `ready`=1.
- `busy`  output  1  1 in WAIT and RESP.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - `req`=1: latch `adr`, `we`, `wdata`, `size`; load the wait counter with `WAIT_STATES`.
  - Go to WAIT, or straight to RESP if `WAIT_STATES`=0.
- **WAIT**
  - Decrement the counter each cycle.
  - Go to RESP on the cycle the counter equals 1.
- **RESP**
  - Drive `ready`=1.
  - Store: write the enabled byte lanes at the clock edge that leaves RESP.
  - Load: `rdata` comes from registered array data.
  - Always return to IDLE.
- `req`, `adr`, `we`, `wdata` and `size` are ignored outside IDLE. The requester may change or drop them after acceptance.
- Word index is `adr[31:2]`. Byte lane is `adr[1:0]`. Halfword lane is `adr[1]`.
- Loads:
  - `b`/`h` sign-extend from bit 7/15.
  - `bu`/`hu` zero-extend.
  - `w` returns the full word.
- Stores:
  - `sb` writes lane `adr[1:0]` from `wdata[7:0]`.
  - `sh` writes the two lanes selected by `adr[1]` from `wdata[15:0]`.
  - `sw` writes all four lanes.
- A store produces `rdata`=0.
- Reset:
  - `ready`=0, `err`=0, `busy`=0, `rdata`=0, state=IDLE, counter=0.
  - Reset mid-access drops the access; no partial write occurs.
  - Array contents are not cleared.

## Timing
- Request accepted at edge N. `ready` is high during cycle N+`WAIT_STATES`+1.
- `ready` and `err` are registered outputs, high for exactly one cycle.
- `busy` rises the cycle after acceptance and falls together with `ready`.
- Back-to-back: the next request is accepted no earlier than the cycle after `ready`. Minimum spacing between acceptances is `WAIT_STATES`+2 cycles.
- The array has one read port and one write port. A load issued right after a store to the same word returns the new data.

## Configuration
- Macro `MEM_RESP_ERR_EN`.
- **Defined:** `err`=1 with `ready` when any of the following holds:
  - `size` is 011, 110 or 111;
  - a halfword access has `adr[0]`=1;
  - a word access has `adr[1:0]`≠0;
  - `adr[31:2]` ≥ `DEPTH_WORDS`.
- **Defined, on a faulting access:** no lanes are written, `rdata`=0, and latency is unchanged.
- **Undefined:**
  - `err` is tied 0.
  - Misaligned accesses use the aligned-down lane (`adr[0]` ignored for h, `adr[1:0]` ignored for w).
  - The index wraps modulo `DEPTH_WORDS`.
  - Illegal `size` is treated as `w`.

## Test plan
- Reset low for 3 cycles, then high → all outputs 0 and `busy`=0. A `lw` at 0x0 after a prior `sw` of 0xDEADBEEF to 0x0 (issued before reset) returns 0xDEADBEEF.
- `WAIT_STATES`=2: `sw` 0x12345678 at 0x10 accepted at edge 0 → `ready` high in cycle 3 only. A following `lw` at 0x10 → `rdata`=0x12345678, `err`=0.
- With 0x80FF7F01 at 0x20:
  - `lb` at 0x23 → 0xFFFFFF80.
  - `lbu` at 0x23 → 0x00000080.
  - `lh` at 0x22 → 0xFFFF80FF.
  - `lhu` at 0x20 → 0x00007F01.
- `sb` 0xAA at 0x21 over 0x00000000, then `lw` at 0x20 → 0x0000AA00. `sh` 0xBEEF at 0x22, then `lw` at 0x20 → 0xBEEFAA00.
- `MEM_RESP_ERR_EN` defined:
  - `lw` at 0x6 → `err`=1, `rdata`=0.
  - `sw` at 0x6 → `err`=1, and word 0x4 is unchanged.
  - `lw` at 4*`DEPTH_WORDS` → `err`=1.
- `req` held high continuously with `WAIT_STATES`=0 → accept, RESP, accept pattern. `ready` pulses every 2nd cycle. Asserting reset during WAIT of an `sw` → no write, `ready` never pulses for it.
